// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared single-precision floating-point types, constants and
//                operand-unpacking helpers for the FP execution units.
//                Contents:
//                  fp_t            - packed sign / exponent / fraction view
//                  FP_QNAN         - canonical quiet NaN
//                  FP_EXP_MAX      - all-ones exponent field (inf / NaN)
//                  FP_BIAS         - exponent bias
//                  fp_seq_state_t  - sequencer states of the multi-cycle units
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam int          FP_BIAS    = 127;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } fp_seq_state_t;

    // Denormals and zero are read with exponent 1 and no hidden bit, so the
    // alignment distance between a denormal and a normal number is correct.
    function automatic logic [7:0] fp_exp_eff(input fp_t v);
        return (v.exp == 8'd0) ? 8'd1 : v.exp;
    endfunction

    // Working significand: hidden, 23 fraction bits, guard, round, sticky.
    function automatic logic [26:0] fp_sig(input fp_t v);
        return {(v.exp != 8'd0), v.frac, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Combinational round-to-nearest-even and pack stage.
//                Takes a normalized (or denormal, exponent 1) 27-bit
//                significand {hidden, frac[22:0], G, R, S} and produces the
//                packed single-precision word plus an overflow flag.
//  Ports       : i_sign      result sign
//                i_exp       biased exponent, 10 bits to absorb carries
//                i_sig       27-bit working significand
//                o_result    packed result (signed inf on overflow)
//                o_overflow  exponent reached 255 after rounding
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack
    import fp_pkg::*;
(
    input  logic        i_sign,
    input  logic [9:0]  i_exp,
    input  logic [26:0] i_sig,
    output fp_t         o_result,
    output logic        o_overflow
);

    logic        w_inc;
    logic [24:0] w_rounded;
    logic [23:0] w_mant;
    logic [9:0]  w_exp;

    always_comb begin
        // Guard set and either above half or odd LSB -> round up.
        w_inc     = i_sig[2] & (i_sig[1] | i_sig[0] | i_sig[3]);
        w_rounded = {1'b0, i_sig[26:3]} + {24'd0, w_inc};

        // A carry out of the mantissa only happens for all-ones + 1, so the
        // dropped bit is always zero.
        if (w_rounded[24]) begin
            w_mant = w_rounded[24:1];
            w_exp  = i_exp + 10'd1;
        end else begin
            w_mant = w_rounded[23:0];
            w_exp  = i_exp;
        end

        o_overflow = (w_exp >= 10'd255);

        if (o_overflow) begin
            o_result = '{sign: i_sign, exp: FP_EXP_MAX, frac: 23'd0};
        end else begin
            // No hidden bit means a denormal (or zero): exponent field is 0.
            // Rounding a denormal up into the hidden bit gives exponent 1.
            o_result = '{sign: i_sign,
                         exp:  w_mant[23] ? w_exp[7:0] : 8'd0,
                         frac: w_mant[22:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_seq
//  Description : Multi-cycle IEEE-754 single-precision add/subtract with
//                valid/ready handshakes. One operand pair is accepted in
//                IDLE, then aligned (1 bit/cycle), added, normalized
//                (1 bit/cycle), rounded (RNE) and held in DONE until taken.
//  Ports       : clk, rst    clock, asynchronous active-high reset
//                in_valid    operand pair valid
//                in_ready    high only in IDLE
//                bin_val1    operand A
//                bin_val2    operand B
//                opcode      0 = A+B, 1 = A-B
//                out_valid   result valid (DONE)
//                out_ready   consumer takes the result
//                bin_out     result, stable while out_valid
//                error       NaN operand, inf-inf, or overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int MAX_ALIGN = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  fp_t  bin_val1,
    input  fp_t  bin_val2,
    input  logic opcode,
    output logic out_valid,
    input  logic out_ready,
    output fp_t  bin_out,
    output logic error
);

    localparam int c_CNT_W = $clog2(MAX_ALIGN + 1);

    fp_seq_state_t        r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [31:0]          r_bin_out;
    logic                 r_error;

    logic                 r_x_sign;
    logic                 r_y_sign;
    logic [26:0]          r_x_sig;
    logic [26:0]          r_y_sig;
    logic [9:0]           r_exp;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [27:0]          r_sum;
    logic                 r_res_sign;

    // Operand unpack / swap (used only on the accept edge)
    logic [7:0]           w_a_exp, w_b_exp, w_x_exp, w_y_exp, w_diff;
    logic [26:0]          w_a_sig, w_b_sig, w_x_sig, w_y_sig;
    logic                 w_b_sign, w_x_sign, w_y_sign, w_a_big;
    logic [c_CNT_W-1:0]   w_cnt_load;

    // Special operands
    logic                 w_a_spec, w_b_spec, w_a_nan, w_b_nan, w_special;
    logic [31:0]          w_spec_res;
    logic                 w_spec_err;

    fp_t                  w_packed;
    logic                 w_overflow;

    always_comb begin
        w_a_exp  = fp_exp_eff(bin_val1);
        w_b_exp  = fp_exp_eff(bin_val2);
        w_a_sig  = fp_sig(bin_val1);
        w_b_sig  = fp_sig(bin_val2);
        w_b_sign = bin_val2.sign ^ opcode;

        // X always holds the larger magnitude, so X-Y is never negative.
        w_a_big = ({w_a_exp, w_a_sig} >= {w_b_exp, w_b_sig});
        if (w_a_big) begin
            w_x_exp = w_a_exp; w_x_sig = w_a_sig; w_x_sign = bin_val1.sign;
            w_y_exp = w_b_exp; w_y_sig = w_b_sig; w_y_sign = w_b_sign;
        end else begin
            w_x_exp = w_b_exp; w_x_sig = w_b_sig; w_x_sign = w_b_sign;
            w_y_exp = w_a_exp; w_y_sig = w_a_sig; w_y_sign = bin_val1.sign;
        end

        w_diff     = w_x_exp - w_y_exp;
        w_cnt_load = (32'(w_diff) >= MAX_ALIGN) ? c_CNT_W'(MAX_ALIGN)
                                                : c_CNT_W'(w_diff);

        w_a_spec  = (bin_val1.exp == FP_EXP_MAX);
        w_b_spec  = (bin_val2.exp == FP_EXP_MAX);
        w_a_nan   = w_a_spec && (bin_val1.frac != 23'd0);
        w_b_nan   = w_b_spec && (bin_val2.frac != 23'd0);
        w_special = w_a_spec | w_b_spec;

        if (w_a_nan || w_b_nan || (w_a_spec && w_b_spec && (bin_val1.sign != w_b_sign))) begin
            w_spec_res = FP_QNAN;
            w_spec_err = 1'b1;
        end else if (w_a_spec) begin
            w_spec_res = {bin_val1.sign, FP_EXP_MAX, 23'd0};
            w_spec_err = 1'b0;
        end else begin
            w_spec_res = {w_b_sign, FP_EXP_MAX, 23'd0};
            w_spec_err = 1'b0;
        end
    end

    fp_round_pack u_round_pack (
        .i_sign     (r_res_sign),
        .i_exp      (r_exp),
        .i_sig      (r_sum[26:0]),
        .o_result   (w_packed),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bin_out   <= 32'h0;
            r_error     <= 1'b0;
            r_x_sign    <= 1'b0;
            r_y_sign    <= 1'b0;
            r_x_sig     <= '0;
            r_y_sig     <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_res_sign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (w_special) begin
                            r_bin_out   <= w_spec_res;
                            r_error     <= w_spec_err;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_x_sign <= w_x_sign;
                            r_y_sign <= w_y_sign;
                            r_x_sig  <= w_x_sig;
                            r_y_sig  <= w_y_sig;
                            r_exp    <= {2'b00, w_x_exp};
                            r_cnt    <= w_cnt_load;
                            r_state  <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (r_cnt == '0) begin
                        r_state <= ADD;
                    end else begin
                        // Bit 0 is sticky: it absorbs everything shifted
                        // past it. After MAX_ALIGN shifts only sticky is left.
                        r_y_sig <= {1'b0, r_y_sig[26:2], r_y_sig[1] | r_y_sig[0]};
                        r_cnt   <= r_cnt - c_CNT_W'(1);
                    end
                end

                ADD: begin
                    if (r_x_sign == r_y_sign) begin
                        r_sum <= {1'b0, r_x_sig} + {1'b0, r_y_sig};
                    end else begin
                        r_sum <= {1'b0, r_x_sig} - {1'b0, r_y_sig};
                    end
                    r_res_sign <= r_x_sign;
                    r_state    <= NORM;
                end

                NORM: begin
                    if (r_sum[27]) begin
                        r_sum   <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
                        r_exp   <= r_exp + 10'd1;
                        r_state <= ROUND;
                    end else if (r_sum == 28'd0) begin
                        // Exact zero is +0 unless both addends were negative.
                        r_res_sign <= r_x_sign & r_y_sign;
                        r_state    <= ROUND;
                    end else if (r_sum[26]) begin
                        r_state <= ROUND;
                    end else if (r_exp > 10'd1) begin
                        r_sum <= {r_sum[26:0], 1'b0};
                        r_exp <= r_exp - 10'd1;
                    end else begin
                        r_state <= ROUND;
                    end
                end

                ROUND: begin
                    r_bin_out   <= w_packed;
                    r_error     <= w_overflow;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin_out;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_seq
//  Description : Self-checking bench for fp_addsub_seq. Directed cases for
//                reset, rounding ties, specials, overflow, backpressure and
//                reset during alignment, followed by random operands checked
//                against an exact-integer IEEE single add/sub reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bin_val1;
    logic [31:0] bin_val2;
    logic        opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] bin_out;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_addsub_seq #(.MAX_ALIGN(27)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_val1  (bin_val1),
        .bin_val2  (bin_val2),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .error     (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operands become exact integers in units of 2^-149, the sum
    // is formed exactly, then rounded to 24 significant bits (RNE).
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                    input logic op, output logic [31:0] r,
                                    output logic e);
        logic         sa, sb, sr;
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic [299:0] one, ma, mb, mag, keep, rem, half;
        int           p, sh;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31] ^ op; eb = b[30:23]; fb = b[22:0];
        one = 300'd1;
        r = 32'h0; e = 1'b0;
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) begin
            r = 32'h7FC00000; e = 1'b1;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            if (sa != sb) begin r = 32'h7FC00000; e = 1'b1; end
            else r = {sa, 8'hFF, 23'd0};
        end else if (ea == 8'hFF) begin
            r = {sa, 8'hFF, 23'd0};
        end else if (eb == 8'hFF) begin
            r = {sb, 8'hFF, 23'd0};
        end else begin
            ma = (ea == 0) ? 300'(fa) : (300'({1'b1, fa}) << (ea - 1));
            mb = (eb == 0) ? 300'(fb) : (300'({1'b1, fb}) << (eb - 1));
            if (sa == sb)      begin mag = ma + mb; sr = sa; end
            else if (ma >= mb) begin mag = ma - mb; sr = sa; end
            else               begin mag = mb - ma; sr = sb; end
            if (mag == 0) begin
                r = {sa & sb, 31'd0};
            end else begin
                p = 0;
                for (int i = 299; i >= 0; i--) begin
                    if (mag[i]) begin p = i; break; end
                end
                if (p <= 23) begin
                    r = {sr, mag[30:0]};
                end else begin
                    sh   = p - 23;
                    keep = mag >> sh;
                    rem  = mag & ((one << sh) - one);
                    half = one << (sh - 1);
                    if (rem > half || (rem == half && keep[0])) keep = keep + one;
                    if (keep[24]) begin keep = keep >> 1; sh++; end
                    if (sh + 1 >= 255) begin r = {sr, 8'hFF, 23'd0}; e = 1'b1; end
                    else r = {sr, 8'(sh + 1), keep[22:0]};
                end
            end
        end
    endfunction

    // One full transaction. lat = edges after the accept edge until
    // out_valid is seen (0 means out_valid rose on the accept edge itself).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input int hold,
                          output logic [31:0] res, output logic err, output int lat);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; bin_val1 = a; bin_val2 = b; opcode = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(out_valid), 32'd1);
        res = bin_out; err = error;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_out"},   bin_out, res);
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_taken_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_taken_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] res, a, b, exp_r;
        logic        err, op, exp_e;
        int          lat, mode;

        rst = 1'b1; in_valid = 1'b0; bin_val1 = '0; bin_val2 = '0;
        opcode = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin_out",   bin_out,        32'h0);
        chk("rst_error",     32'(error),     32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 0, res, err, lat);
        chk("one_plus_one_res", res, 32'h40000000);
        chk("one_plus_one_err", 32'(err), 32'd0);
        chk("one_plus_one_lat", 32'(lat), 32'd4);

        run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 0, res, err, lat);
        chk("one_minus_one_res", res, 32'h00000000);
        chk("one_minus_one_err", 32'(err), 32'd0);
        chk("one_minus_one_lat", 32'(lat), 32'd4);

        run_op("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 0, res, err, lat);
        chk("tie_even_res", res, 32'h3F800000);
        chk("tie_even_lat", 32'(lat), 32'd28);

        run_op("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 0, res, err, lat);
        chk("tie_odd_res", res, 32'h3F800002);

        run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 0, res, err, lat);
        chk("inf_minus_inf_res", res, 32'h7FC00000);
        chk("inf_minus_inf_err", 32'(err), 32'd1);
        chk("inf_minus_inf_lat", 32'(lat), 32'd0);

        run_op("ninf_plus_ninf", 32'hFF800000, 32'hFF800000, 1'b0, 0, res, err, lat);
        chk("ninf_plus_ninf_res", res, 32'hFF800000);
        chk("ninf_plus_ninf_err", 32'(err), 32'd0);

        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, res, err, lat);
        chk("overflow_res", res, 32'h7F800000);
        chk("overflow_err", 32'(err), 32'd1);

        run_op("backpressure", 32'h40400000, 32'hBF800000, 1'b0, 10, res, err, lat);
        chk("backpressure_res", res, 32'h40000000);

        // Reset while the alignment loop is still shifting.
        @(negedge clk);
        in_valid = 1'b1; bin_val1 = 32'h3F800000; bin_val2 = 32'h33800000; opcode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_bin_out",   bin_out,        32'h0);
        @(negedge clk); rst = 1'b0;
        run_op("after_rst", 32'h3FC00000, 32'h3F000000, 1'b0, 0, res, err, lat);
        chk("after_rst_res", res, 32'h40000000);
        chk("after_rst_lat", 32'(lat), 32'd5);

        for (int n = 0; n < 300; n++) begin
            a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            case (mode)
                1: begin
                    if (a[30:23] == 8'hFF) a[30:23] = 8'hFE;
                    b[30:23] = a[30:23] ^ 8'($urandom_range(0, 1));
                    op = a[31] ^ b[31] ^ 1'b1;
                end
                2: begin
                    a[30:23] = 8'd0;
                    b[30:23] = 8'($urandom_range(0, 2));
                end
                3: begin
                    a[30:23] = 8'($urandom_range(250, 254));
                    b[30:23] = 8'($urandom_range(240, 254));
                end
                default: ;
            endcase
            ref_add(a, b, op, exp_r, exp_e);
            run_op("rand", a, b, op, 0, res, err, lat);
            chk($sformatf("rand_res %h %0d %h", a, op, b), res, exp_r);
            chk($sformatf("rand_err %h %0d %h", a, op, b), 32'(err), 32'(exp_e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
